// File: rtl/logip_pkg.sv
// Shared definitions for the logic-analyser command path: SUMP opcodes,
// the long-command flag position and the framer state type.
package logip_pkg;

   localparam logic [7:0] OPC_RESET = 8'h00;
   localparam logic [7:0] OPC_ARM   = 8'h01;
   localparam logic [7:0] OPC_ID    = 8'h02;
   localparam logic [7:0] OPC_XON   = 8'h11;
   localparam logic [7:0] OPC_XOFF  = 8'h13;

   localparam int LONG_BIT = 7;

   typedef enum logic [0:0] {
      FR_IDLE = 1'b0,
      FR_ARGS = 1'b1
   } framer_state_e;

endpackage

// File: rtl/cmd_framer.sv
// Assembles UART bytes into SUMP short/long commands, strobes exec_o per
// completed command and drops stale partial long commands after a timeout.
module cmd_framer
   import logip_pkg::*;
#(
   parameter int TIMEOUT = 1_000_000
)
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [7:0]  rx_dat_i,
   input  logic        rx_stb_i,
   output logic [7:0]  opc_o,
   output logic [31:0] cmd_o,
   output logic        exec_o,
   output logic        busy_o,
   output logic        err_o
);

   framer_state_e state_q, state_d;
   logic [7:0]    opc_q, opc_d;
   logic [31:0]   cmd_q, cmd_d;
   logic          exec_q, exec_d;
   logic          err_q, err_d;
   logic [7:0]    arg_opc_q, arg_opc_d;
   logic [31:0]   shift_q, shift_d;
   logic [1:0]    bcnt_q, bcnt_d;
   logic          tmo_hit_s;

   // Inter-byte timeout; the expiry fires on the cycle the count would reach TIMEOUT
   generate
      if (TIMEOUT > 0) begin : g_tmo
         localparam int TW = $clog2(TIMEOUT + 1);
         localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
         localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
         logic [TW-1:0] tmo_q, tmo_d;

         // Timeout counter next-state
         always_comb begin
            tmo_d = tmo_q;
            if ((state_q == FR_ARGS) && !rx_stb_i) begin
               if (tmo_q == TMO_MAX) begin
                  tmo_d = tmo_q;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
            end else begin
               tmo_d = '0;
            end
         end

         // Timeout counter register
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               tmo_q <= '0;
            end else begin
               tmo_q <= tmo_d;
            end
         end

         assign tmo_hit_s = (state_q == FR_ARGS) && !rx_stb_i && (tmo_q == TMO_LAST);
      end else begin : g_no_tmo
         assign tmo_hit_s = 1'b0;
      end
   endgenerate

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= FR_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         FR_IDLE: begin
            if (rx_stb_i && rx_dat_i[LONG_BIT]) begin
               state_d = FR_ARGS;
            end else begin
               state_d = FR_IDLE;
            end
         end
         FR_ARGS: begin
            if (rx_stb_i && (bcnt_q == 2'd3)) begin
               state_d = FR_IDLE;
            end else if (tmo_hit_s) begin
               state_d = FR_IDLE;
            end else begin
               state_d = FR_ARGS;
            end
         end
         default: state_d = FR_IDLE;
      endcase
   end

   // Output and argument datapath next-state
   always_comb begin
      opc_d     = opc_q;
      cmd_d     = cmd_q;
      exec_d    = 1'b0;
      err_d     = 1'b0;
      arg_opc_d = arg_opc_q;
      shift_d   = shift_q;
      bcnt_d    = bcnt_q;
      case (state_q)
         FR_IDLE: begin
            if (rx_stb_i && !rx_dat_i[LONG_BIT]) begin
               opc_d  = rx_dat_i;
               cmd_d  = 32'h0000_0000;
               exec_d = 1'b1;
            end else if (rx_stb_i) begin
               arg_opc_d = rx_dat_i;
               shift_d   = 32'h0000_0000;
               bcnt_d    = 2'd0;
            end else begin
               bcnt_d = bcnt_q;
            end
         end
         FR_ARGS: begin
            if (rx_stb_i) begin
               // Argument bytes arrive little-endian
               case (bcnt_q)
                  2'd0:    shift_d[7:0]   = rx_dat_i;
                  2'd1:    shift_d[15:8]  = rx_dat_i;
                  2'd2:    shift_d[23:16] = rx_dat_i;
                  2'd3:    shift_d[31:24] = rx_dat_i;
                  default: shift_d        = shift_q;
               endcase
               bcnt_d = bcnt_q + 2'd1;
               if (bcnt_q == 2'd3) begin
                  opc_d  = arg_opc_q;
                  cmd_d  = {rx_dat_i, shift_q[23:0]};
                  exec_d = 1'b1;
               end else begin
                  exec_d = 1'b0;
               end
            end else if (tmo_hit_s) begin
               err_d = 1'b1;
            end else begin
               err_d = 1'b0;
            end
         end
         default: begin
            exec_d = 1'b0;
         end
      endcase
   end

   // Output and argument datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         opc_q     <= 8'h00;
         cmd_q     <= 32'h0000_0000;
         exec_q    <= 1'b0;
         err_q     <= 1'b0;
         arg_opc_q <= 8'h00;
         shift_q   <= 32'h0000_0000;
         bcnt_q    <= 2'd0;
      end else begin
         opc_q     <= opc_d;
         cmd_q     <= cmd_d;
         exec_q    <= exec_d;
         err_q     <= err_d;
         arg_opc_q <= arg_opc_d;
         shift_q   <= shift_d;
         bcnt_q    <= bcnt_d;
      end
   end

   assign opc_o  = opc_q;
   assign cmd_o  = cmd_q;
   assign exec_o = exec_q;
   assign err_o  = err_q;
   assign busy_o = (state_q == FR_ARGS);

endmodule

// File: tb/tb_cmd_framer.sv
// Directed bench for cmd_framer: a byte-queue model predicts every output each
// cycle, and literal expectations pin the key command results.
module tb_cmd_framer;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_dat = 8'h00;
   logic        rx_stb = 1'b0;
   logic [7:0]  opc;
   logic [31:0] cmd;
   logic        exec, busy, err;

   int n_cmp = 0;
   int n_bad = 0;

   cmd_framer #(.TIMEOUT(TMO)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .rx_dat_i (rx_dat),
      .rx_stb_i (rx_stb),
      .opc_o    (opc),
      .cmd_o    (cmd),
      .exec_o   (exec),
      .busy_o   (busy),
      .err_o    (err)
   );

   always #5 clk = ~clk;

   // Model: bytes of the pending long command, idle cycles since last byte
   logic [7:0]  mq[$];
   int          idle_m = 0;
   logic [7:0]  exp_opc = 8'h00;
   logic [31:0] exp_cmd = 32'h0;
   logic        exp_exec = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         idle_m   <= 0;
         exp_opc  <= 8'h00;
         exp_cmd  <= 32'h0;
         exp_exec <= 1'b0;
         exp_err  <= 1'b0;
         exp_busy <= 1'b0;
      end else begin
         exp_exec <= 1'b0;
         exp_err  <= 1'b0;
         if (rx_stb) begin
            idle_m <= 0;
            if (mq.size() == 0 && !rx_dat[7]) begin
               exp_exec <= 1'b1;
               exp_opc  <= rx_dat;
               exp_cmd  <= 32'h0;
            end else begin
               mq.push_back(rx_dat);
               if (mq.size() == 5) begin
                  exp_exec <= 1'b1;
                  exp_opc  <= mq[0];
                  exp_cmd  <= {mq[4], mq[3], mq[2], mq[1]};
                  mq.delete();
               end
            end
         end else if (mq.size() != 0) begin
            if (idle_m + 1 == TMO) begin
               exp_err <= 1'b1;
               mq.delete();
               idle_m  <= 0;
            end else begin
               idle_m <= idle_m + 1;
            end
         end
         exp_busy <= (mq.size() != 0);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
      end
   endtask

   // Per-cycle comparison against the model
   initial begin
      forever begin
         @(negedge clk);
         chk("opc",  {24'h0, opc}, {24'h0, exp_opc});
         chk("cmd",  cmd, exp_cmd);
         chk("exec", {31'h0, exec}, {31'h0, exp_exec});
         chk("err",  {31'h0, err}, {31'h0, exp_err});
         chk("busy", {31'h0, busy}, {31'h0, exp_busy});
         chk("excl", {31'h0, exec & err}, 32'h0);
      end
   end

   task automatic send(input logic [7:0] b, input int gap);
      rx_dat = b;
      rx_stb = 1'b1;
      @(negedge clk);
      rx_stb = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_exec(input string nm, input logic [7:0] o, input logic [31:0] c);
      chk({nm, "_exec"}, {31'h0, exec}, 32'h1);
      chk({nm, "_opc"}, {24'h0, opc}, {24'h0, o});
      chk({nm, "_cmd"}, cmd, c);
   endtask

   initial begin
      // Reset with random receive activity
      for (int i = 0; i < 6; i++) begin
         rx_dat = 8'($urandom);
         rx_stb = 1'($urandom);
         @(negedge clk);
      end
      rx_stb = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      chk("rel_out", {opc, exec, busy, err}, 11'h0);
      chk("rel_cmd", cmd, 32'h0);

      // Short command
      send(8'h02, 0);
      chk_exec("short", 8'h02, 32'h0);
      chk("short_busy", {31'h0, busy}, 32'h0);
      idle(2);

      // Long command with gaps
      send(8'h80, 3);
      chk("long_busy", {31'h0, busy}, 32'h1);
      send(8'h11, 0);
      send(8'h22, 7);
      send(8'h33, 1);
      chk("long_noexec", {31'h0, exec}, 32'h0);
      send(8'h44, 0);
      chk_exec("long", 8'h80, 32'h4433_2211);
      chk("long_busy_fall", {31'h0, busy}, 32'h0);
      idle(1);

      // Timeout: err 16 cycles after last byte, outputs unchanged
      send(8'hC0, 0);
      send(8'hAA, 0);
      idle(15);
      chk("tmo_early", {31'h0, err}, 32'h0);
      idle(1);
      chk("tmo_err", {31'h0, err}, 32'h1);
      chk("tmo_opc", {24'h0, opc}, 32'h80);
      chk("tmo_cmd", cmd, 32'h4433_2211);
      chk("tmo_busy", {31'h0, busy}, 32'h0);
      send(8'h01, 0);
      chk_exec("after_tmo", 8'h01, 32'h0);

      // Byte on the expiry cycle wins
      send(8'hC0, 0);
      send(8'hAA, 0);
      idle(15);
      send(8'hBB, 0);
      chk("exp_byte_err", {31'h0, err}, 32'h0);
      chk("exp_byte_busy", {31'h0, busy}, 32'h1);
      send(8'hCC, 0);
      send(8'hDD, 0);
      chk_exec("exp_byte", 8'hC0, 32'hDDCC_BBAA);
      idle(1);

      // Back-to-back: long 0x81 with zero args, then short 0x00
      send(8'h81, 0);
      for (int i = 0; i < 4; i++) send(8'h00, 0);
      chk_exec("b2b_long", 8'h81, 32'h0);
      send(8'h00, 0);
      chk_exec("b2b_short", 8'h00, 32'h0);
      idle(2);

      // Resync: stray arguments then five 0x00
      send(8'h85, 0);
      send(8'hA1, 0);
      send(8'hA2, 0);
      send(8'hA3, 0);
      send(8'h00, 0);
      chk_exec("resync_long", 8'h85, 32'h00A3_A2A1);
      for (int i = 0; i < 4; i++) send(8'h00, 0);
      chk_exec("resync_short", 8'h00, 32'h0);
      idle(1);
      chk("resync_idle", {31'h0, busy}, 32'h0);

      // Reset mid-command
      send(8'h82, 0);
      send(8'h55, 0);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_busy", {31'h0, busy}, 32'h0);
      chk("mid_rst_out", {opc, exec, err}, 10'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(1);
      send(8'h02, 0);
      chk_exec("post_rst", 8'h02, 32'h0);
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
